// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
// The partial remainder stays below the divisor (at most 2^(WIDTH-1)),
// so the shifted remainder always fits in WIDTH+1 bits and the sign bit
// of the trial subtraction is a reliable "went negative" indicator.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Bring the next dividend bit (MSB of the quotient register) into the remainder.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign trial   = shifted - {1'b0, div};

    // Keep the difference when non-negative, otherwise restore.
    assign rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/sequential_divider.sv
// Signed sequential restoring divider: WIDTH iterations per operation,
// truncating toward zero, with divide-by-zero and overflow flags.
module sequential_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quo,
    output logic [WIDTH-1:0] Rem,
    output logic             ready,
    output logic             DBZ,
    output logic             OVF
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             sign_a, sign_b, ovf_pend;
    logic             div_zero, start, last;

    // Magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned.
    assign a_mag    = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    assign b_mag    = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
    assign div_zero = (B == '0);
    assign start    = (state == IDLE) && enable && !div_zero;
    assign last     = (state == BUSY) && (cnt == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .div     (div_q),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    // Sign correction of the final step: quotient negated on differing signs,
    // remainder follows the dividend.
    assign quo_fix = ((sign_a ^ sign_b) && (quo_nxt != '0)) ? -quo_nxt : quo_nxt;
    assign rem_fix = sign_a ? -rem_nxt : rem_nxt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and ready decode.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = BUSY;
            end
            BUSY: begin
                if (cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration registers and result/flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            ovf_pend <= 1'b0;
            Quo      <= '0;
            Rem      <= '0;
            DBZ      <= 1'b0;
            OVF      <= 1'b0;
        end else if (state == IDLE) begin
            if (enable && div_zero) begin
                DBZ <= 1'b1;
                OVF <= 1'b0;
                Quo <= '0;
                Rem <= A;
            end else if (start) begin
                rem_q    <= '0;
                quo_q    <= a_mag;
                div_q    <= b_mag;
                sign_a   <= A[WIDTH-1];
                sign_b   <= B[WIDTH-1];
                ovf_pend <= (A == MIN_VAL) && (B == '1);
                DBZ      <= 1'b0;
                OVF      <= 1'b0;
                cnt      <= CW'(WIDTH - 1);
            end
        end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt - CW'(1);
            if (last) begin
                Quo <= quo_fix;
                Rem <= rem_fix;
                OVF <= ovf_pend;
            end
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and randomized checks of sequential_divider against a plain
// arithmetic reference model.
module tb_sequential_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, enable;
    logic [W-1:0] A, B, Quo, Rem;
    logic         ready, DBZ, OVF;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sequential_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .A      (A),
        .B      (B),
        .Quo    (Quo),
        .Rem    (Rem),
        .ready  (ready),
        .DBZ    (DBZ),
        .OVF    (OVF)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Truncating signed division computed with 64-bit arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output logic ovf);
        longint sa, sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        ovf = 1'b0;
        if (sb == 0) begin
            q   = '0;
            r   = a;
            dbz = 1'b1;
        end else if (sa == -longint'(64'sd2147483648) && sb == -1) begin
            q   = a;
            r   = '0;
            ovf = 1'b1;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endtask

    // One operation: pulse enable, optionally poke enable while busy, scramble
    // A/B during BUSY, count edges to completion and compare with the model.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag, input bit poke);
        logic [W-1:0] eq, er;
        logic         edbz, eovf;
        int           n;
        model(a, b, eq, er, edbz, eovf);
        @(negedge clk);
        A = a; B = b; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        A = $urandom; B = $urandom;
        if (edbz) begin
            check_b({tag, " dbz ready"}, ready, 1'b1);
            check_b({tag, " dbz flag"}, DBZ, 1'b1);
            check_b({tag, " dbz ovf"}, OVF, 1'b0);
            check({tag, " dbz quo"}, Quo, '0);
            check({tag, " dbz rem"}, Rem, er);
            repeat (3) begin
                @(posedge clk);
                #1;
                check_b({tag, " dbz ready held"}, ready, 1'b1);
            end
            return;
        end
        check_b({tag, " busy after capture"}, ready, 1'b0);
        n = 0;
        while (!ready && n < 100) begin
            enable = poke && (n % 4 == 1) && (n < 28);
            if (enable) begin A = 32'd1; B = 32'd1; end
            @(posedge clk);
            #1;
            n++;
        end
        enable = 1'b0;
        check({tag, " latency"}, W'(n), W'(32));
        check({tag, " quo"}, Quo, eq);
        check({tag, " rem"}, Rem, er);
        check_b({tag, " dbz"}, DBZ, edbz);
        check_b({tag, " ovf"}, OVF, eovf);
    endtask

    initial begin
        int           n;
        logic [W-1:0] ra, rb;

        reset = 1'b1; enable = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_b("reset ready", ready, 1'b1);
        check("reset quo", Quo, '0);
        check("reset rem", Rem, '0);
        check_b("reset dbz", DBZ, 1'b0);
        check_b("reset ovf", OVF, 1'b0);

        run_op(32'd100, 32'd7, "100/7", 1'b0);
        check("100/7 quo const", Quo, 32'd14);
        check("100/7 rem const", Rem, 32'd2);
        run_op(-32'sd100, 32'd7, "-100/7", 1'b0);
        check("-100/7 quo const", Quo, 32'hFFFF_FFF2);
        check("-100/7 rem const", Rem, 32'hFFFF_FFFE);
        run_op(32'd100, -32'sd7, "100/-7", 1'b0);
        run_op(32'd5, 32'd0, "5/0", 1'b0);
        check("5/0 rem const", Rem, 32'd5);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "min/-1", 1'b0);
        check("min/-1 quo const", Quo, 32'h8000_0000);
        run_op(32'h8000_0000, 32'd1, "min/1", 1'b0);
        run_op(32'd7, 32'h8000_0000, "7/min", 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, "min/min", 1'b0);

        // Abort mid-operation with reset; prior outputs are nonzero.
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "pre-abort", 1'b0);
        @(negedge clk);
        A = 32'd100; B = 32'd7; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_b("abort ready", ready, 1'b1);
        check("abort quo", Quo, '0);
        check("abort rem", Rem, '0);
        check_b("abort dbz", DBZ, 1'b0);
        check_b("abort ovf", OVF, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_b("idle after abort", ready, 1'b1);
        run_op(32'd100, 32'd7, "poked 100/7", 1'b1);

        // Back-to-back with enable held high.
        @(negedge clk);
        A = 32'd1000; B = 32'd3; enable = 1'b1;
        @(posedge clk);
        #1;
        A = 32'd7; B = 32'd7;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b first latency", W'(n), W'(32));
        check("b2b 1000/3 quo", Quo, 32'd333);
        check("b2b 1000/3 rem", Rem, 32'd1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        check_b("b2b second capture at edge 33", ready, 1'b0);
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b second latency", W'(n), W'(32));
        check("b2b 7/7 quo", Quo, 32'd1);
        check("b2b 7/7 rem", Rem, 32'd0);

        // Randomized signed pairs, mixing wide, small and zero divisors.
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            case (k % 4)
                0: rb = $urandom;
                1: rb = W'($signed($urandom_range(0, 16)) - 8);
                2: begin rb = $urandom >> $urandom_range(0, 31); ra = ra >> 4; end
                default: begin rb = W'($signed($urandom_range(0, 6)) - 3); ra = -ra; end
            endcase
            run_op(ra, rb, $sformatf("rand%0d", k), (k % 5 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
